// File: rtl/cache_arbiter.sv
// Arbitrates icache and dcache line transactions onto one physical-memory port.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise the dcache wins contention.
module cache_arbiter (
    input  logic         clk,
    input  logic         reset,

    input  logic         i_mem_read,
    input  logic         i_mem_write,
    input  logic [15:0]  i_mem_address,
    input  logic [127:0] i_mem_wdata,
    output logic         i_mem_resp,
    output logic [127:0] i_mem_rdata,

    input  logic         d_mem_read,
    input  logic         d_mem_write,
    input  logic [15:0]  d_mem_address,
    input  logic [127:0] d_mem_wdata,
    output logic         d_mem_resp,
    output logic [127:0] d_mem_rdata,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q;
    logic                grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [LINE_W-1:0]   rdata_q;
    logic                pmem_read_q;
    logic                pmem_write_q;
    logic                i_resp_q;
    logic                d_resp_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic                last_q;
`endif

    logic                i_req_c;
    logic                d_req_c;
    logic                pick_d_c;
    logic                pick_write_c;

    // Winner selection for the current IDLE cycle; a write takes precedence over a read.
    always_comb begin
        i_req_c      = i_mem_read | i_mem_write;
        d_req_c      = d_mem_read | d_mem_write;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        pick_d_c     = d_req_c & (~i_req_c | ~last_q);
`else
        pick_d_c     = d_req_c;
`endif
        pick_write_c = pick_d_c ? d_mem_write : i_mem_write;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    i_resp_q <= 1'b0;
                    d_resp_q <= 1'b0;
                    if (i_req_c | d_req_c) begin
                        grant_q      <= pick_d_c;
                        addr_q       <= pick_d_c ? d_mem_address : i_mem_address;
                        wdata_q      <= pick_d_c ? d_mem_wdata : i_mem_wdata;
                        pmem_read_q  <= ~pick_write_c;
                        pmem_write_q <= pick_write_c;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        rdata_q      <= pmem_rdata;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        i_resp_q     <= ~grant_q;
                        d_resp_q     <= grant_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                        last_q       <= grant_q;
`endif
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    i_resp_q <= 1'b0;
                    d_resp_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                    i_resp_q     <= 1'b0;
                    d_resp_q     <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_mem_resp   = i_resp_q;
    assign d_mem_resp   = d_resp_q;
    assign i_mem_rdata  = rdata_q;
    assign d_mem_rdata  = rdata_q;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the LC-3b instruction cache and data cache onto a single physical-memory port. It sits directly downstream of each cache's memory-side signals: line address, 128-bit write-back data and 128-bit fill data. It latches the winning request, runs one memory transaction, and returns a single-cycle response to that cache. Losing and later requests wait; no request is ever dropped.

## Interface
Parameters:
- none; widths are fixed by `lc3b_types`: `lc3b_word` is 16 bits, `lc3b_8words` is 128 bits.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; returns the block to IDLE.
- `i_mem_read` in 1: icache line-fill request; held until `i_mem_resp`.
- `i_mem_write` in 1: icache write-back request; held until `i_mem_resp`.
- `i_mem_address` in 16: icache line address, bits [3:0] = 0.
- `i_mem_wdata` in 128: icache write-back line.
- `i_mem_resp` out 1: one-cycle completion pulse to the icache.
- `i_mem_rdata` out 128: fill line; valid while `i_mem_resp` = 1.
- `d_mem_read`, `d_mem_write`, `d_mem_address`, `d_mem_wdata`, `d_mem_resp`, `d_mem_rdata`: same as the i_ set, for the dcache.
- `pmem_read` out 1: physical read strobe.
- `pmem_write` out 1: physical write strobe.
- `pmem_address` out 16: physical line address.
- `pmem_wdata` out 128: physical write data.
- `pmem_rdata` in 128: physical read data; valid with `pmem_resp`.
- `pmem_resp` in 1: physical completion; a single-cycle pulse.

## Operation
- FSM states: IDLE, BUSY, RESP. A `grant` register records the serviced client (0 = I, 1 = D). A `last` register records the last-serviced client.
- Request rule: a client requests when its read or write input is 1. If read and write are both 1, the transaction is a write.
- IDLE:
  - If no client requests, stay in IDLE.
  - Otherwise select the winner per Configuration. Latch its address, its wdata and its op (read or write) into internal registers, set `grant`, and go to BUSY.
- BUSY:
  - Drive `pmem_read` or `pmem_write` (exactly one) from the latched op. Drive `pmem_address` and `pmem_wdata` from the latched registers.
  - When `pmem_resp` = 1: latch `pmem_rdata` into the rdata register, update `last` to `grant`, and go to RESP.
- RESP:
  - Assert the granted client's `*_mem_resp` for exactly this cycle. Both `*_mem_rdata` outputs show the rdata register.
  - Go to IDLE. The client drops its request in the following cycle, so IDLE never re-grants a completed request.
- A client's input changes during BUSY/RESP are ignored, because the latched copies drive pmem.
- pmem strobes are 0 in IDLE and RESP.
- `pmem_resp` outside BUSY is ignored.

## Timing
- Reset values: state IDLE, `grant` 0, `last` 0 (I), all `*_resp` 0, `pmem_read`/`pmem_write` 0, address/wdata/rdata registers 0.
- A request seen in IDLE in cycle t causes the pmem strobe to assert in cycle t+1.
- If `pmem_resp` arrives in cycle k, the client resp is in cycle k+1. Minimum round trip: request cycle 0, resp cycle 3 (pmem answering in cycle 2 of BUSY).
- A new grant can occur at the earliest 2 cycles after the previous client resp.
- Both clients requesting in the same IDLE cycle: exactly one is granted. The other is granted on the next IDLE visit in which it is still requesting.
- Reset asserted mid-transaction (BUSY/RESP): next state is IDLE, strobes drop the following cycle, and the pending transaction is abandoned with no client resp.
- Outputs are registered state decodes; there is no combinational path from `*_mem_read`/`write` to pmem.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined: on a simultaneous request, grant the client not equal to `last`. After reset the first contended grant goes to D, because `last` resets to I.
- Not defined: fixed priority, D always wins contention, and `last` is unused. Single requests are granted regardless of mode.

## Test plan
- Solo I read: `i_mem_read`=1, address 0x1230; pmem returns 0xA5..A5 after 3 BUSY cycles. Required: `pmem_read`=1 and `pmem_address`=0x1230 only during BUSY; `i_mem_resp`=1 for one cycle with `i_mem_rdata`=0xA5..A5; `d_mem_resp` stays 0.
- Solo D write: `d_mem_write`=1, address 0x8040, wdata 0x0123..CDEF. Required: `pmem_write`=1 with that address/data, `pmem_read`=0, and a single `d_mem_resp` pulse.
- Contention after reset: I and D read together, each held until its resp. Round-robin: D served first, then I, then D again on repeat. Fixed mode: D always served first.
- Input change during BUSY: `d_mem_address` changes from 0x8040 to 0xFFF0 mid-transaction. Required: `pmem_address` stays 0x8040 until `pmem_resp`.
- Read and write both 1 on I: required `pmem_write`=1, `pmem_read`=0.
- Reset in BUSY: required IDLE next cycle, strobes 0, no resp pulse; a later `pmem_resp` is ignored.
